// File: rtl/mmio_io_ctrl_pkg.sv
// Shared register map, KCTRL bit positions and 7-segment decode for the board I/O controller.
package mmio_io_ctrl_pkg;

  localparam logic [4:0] OFS_HEX   = 5'h00;
  localparam logic [4:0] OFS_LEDR  = 5'h04;
  localparam logic [4:0] OFS_LEDG  = 5'h08;
  localparam logic [4:0] OFS_KDATA = 5'h10;
  localparam logic [4:0] OFS_SDATA = 5'h14;
  localparam logic [4:0] OFS_KCTRL = 5'h18;

  localparam int KCTRL_READY   = 0;
  localparam int KCTRL_OVERRUN = 2;

  // Active-low segments in gfedcba order.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/mmio_io_ctrl_if.sv
// Data-memory bus view of the I/O window: the CPU is master, the controller is slave.
interface mmio_io_ctrl_if #(
  parameter int DBITS = 32
) ();

  logic [DBITS-1:0] addr;
  logic [DBITS-1:0] wrdata;
  logic             we;
  logic             re;
  logic             hit;
  logic [DBITS-1:0] rddata;

  modport master (
    output addr, wrdata, we, re,
    input  hit, rddata
  );

  modport slave (
    input  addr, wrdata, we, re,
    output hit, rddata
  );

endinterface

// File: rtl/mmio_io_ctrl_debounce.sv
// One input channel: 2-flop synchroniser followed by a hold-time debouncer.
module mmio_io_ctrl_debounce #(
  parameter int CYCLES = 100000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level
);

  localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  // Any cycle agreeing with the accepted level restarts the hold count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        cnt   <= '0;
        level <= sync2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mmio_io_ctrl.sv
// Memory-mapped board I/O: debounced keys/switches, sticky key-press status, LED and HEX registers.
module mmio_io_ctrl
  import mmio_io_ctrl_pkg::*;
#(
  parameter int               DBITS           = 32,
  parameter logic [DBITS-1:0] ADDR_BASE       = 32'hF0000000,
  parameter int               NKEYS           = 4,
  parameter int               NSW             = 10,
  parameter int               NLEDR           = 10,
  parameter int               NLEDG           = 8,
  parameter int               NHEX            = 4,
  parameter int               DEBOUNCE_CYCLES = 100000
) (
  input  logic               clk,
  input  logic               reset,
  mmio_io_ctrl_if.slave      bus,
  input  logic [NKEYS-1:0]   KEY,
  input  logic [NSW-1:0]     SW,
  output logic [NLEDR-1:0]   LEDR,
  output logic [NLEDG-1:0]   LEDG,
  output logic [7*NHEX-1:0]  HEX
);

  logic [4*NHEX-1:0] hex_q;
  logic [NKEYS-1:0]  kdata;
  logic [NKEYS-1:0]  kdata_q;
  logic [NSW-1:0]    sdata;
  logic              ready;
  logic              overrun;
  logic [4:0]        ofs;
  logic              wr_hit;
  logic              kdata_read;
  logic              kctrl_write;
  logic              press;
  logic              unused_bits;

  // Keys are inverted before synchronising so the debounced level reads 1 = pressed.
  for (genvar i = 0; i < NKEYS; i++) begin : g_key
    mmio_io_ctrl_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk   (clk),
      .reset (reset),
      .raw   (~KEY[i]),
      .level (kdata[i])
    );
  end

  for (genvar i = 0; i < NSW; i++) begin : g_sw
    mmio_io_ctrl_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk   (clk),
      .reset (reset),
      .raw   (SW[i]),
      .level (sdata[i])
    );
  end

  assign ofs         = bus.addr[4:0];
  assign bus.hit     = (bus.addr[DBITS-1:5] == ADDR_BASE[DBITS-1:5]);
  assign wr_hit      = bus.hit & bus.we;
  assign kdata_read  = bus.hit & bus.re & (ofs == OFS_KDATA);
  assign kctrl_write = wr_hit & (ofs == OFS_KCTRL);
  assign press       = |(kdata & ~kdata_q);
  assign unused_bits = ^{bus.wrdata, bus.addr};

  always_comb begin
    bus.rddata = '0;
    if (bus.hit) begin
      case (ofs)
        OFS_HEX:   bus.rddata = DBITS'(hex_q);
        OFS_LEDR:  bus.rddata = DBITS'(LEDR);
        OFS_LEDG:  bus.rddata = DBITS'(LEDG);
        OFS_KDATA: bus.rddata = DBITS'(kdata);
        OFS_SDATA: bus.rddata = DBITS'(sdata);
        OFS_KCTRL: bus.rddata = DBITS'({overrun, 1'b0, ready});
        default:   bus.rddata = '0;
      endcase
    end
  end

  // A press in the same cycle as a clear wins; a press that coincides with the
  // KDATA read which consumes the previous event is not counted as an overrun.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hex_q   <= '0;
      LEDR    <= '0;
      LEDG    <= '0;
      kdata_q <= '0;
      ready   <= 1'b0;
      overrun <= 1'b0;
    end else begin
      kdata_q <= kdata;
      if (wr_hit && ofs == OFS_HEX)  hex_q <= bus.wrdata[4*NHEX-1:0];
      if (wr_hit && ofs == OFS_LEDR) LEDR  <= bus.wrdata[NLEDR-1:0];
      if (wr_hit && ofs == OFS_LEDG) LEDG  <= bus.wrdata[NLEDG-1:0];

      if (press)
        ready <= 1'b1;
      else if (kdata_read || (kctrl_write && !bus.wrdata[KCTRL_READY]))
        ready <= 1'b0;

      if (press && ready && !kdata_read)
        overrun <= 1'b1;
      else if (kctrl_write && !bus.wrdata[KCTRL_OVERRUN])
        overrun <= 1'b0;
    end
  end

  for (genvar i = 0; i < NHEX; i++) begin : g_hex
    assign HEX[7*i+6:7*i] = seg7(hex_q[4*i+3:4*i]);
  end

endmodule

// File: tb/tb_mmio_io_ctrl.sv
// Directed bench for mmio_io_ctrl with a queue-based scoreboard sampled after each falling edge.
module tb_mmio_io_ctrl;

  localparam logic [31:0] BASE   = 32'hF0000000;
  localparam logic [31:0] A_HEX  = BASE + 32'h00;
  localparam logic [31:0] A_LEDR = BASE + 32'h04;
  localparam logic [31:0] A_LEDG = BASE + 32'h08;
  localparam logic [31:0] A_KDAT = BASE + 32'h10;
  localparam logic [31:0] A_SDAT = BASE + 32'h14;
  localparam logic [31:0] A_KCTL = BASE + 32'h18;

  localparam int SEL_RD   = 0;
  localparam int SEL_HIT  = 1;
  localparam int SEL_HEX  = 2;
  localparam int SEL_LEDR = 3;
  localparam int SEL_LEDG = 4;

  localparam logic [31:0] HEX_RESET = {4'h0, 7'h40, 7'h40, 7'h40, 7'h40};
  localparam logic [31:0] HEX_A5C3  = {4'h0, 7'h08, 7'h12, 7'h46, 7'h30};

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
  } expect_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] KEY;
  logic [9:0] SW;
  logic [9:0] LEDR;
  logic [7:0] LEDG;
  logic [27:0] HEX;

  expect_t scoreQ[$];
  int      testsRun = 0;
  int      testsFailed = 0;

  mmio_io_ctrl_if #(.DBITS(32)) bus ();

  mmio_io_ctrl #(
    .DBITS(32), .ADDR_BASE(BASE), .NKEYS(4), .NSW(10),
    .NLEDR(10), .NLEDG(8), .NHEX(4), .DEBOUNCE_CYCLES(8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .KEY   (KEY),
    .SW    (SW),
    .LEDR  (LEDR),
    .LEDG  (LEDG),
    .HEX   (HEX)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] d,
                               input logic w, input logic r);
    bus.addr   = a;
    bus.wrdata = d;
    bus.we     = w;
    bus.re     = r;
  endtask

  task automatic checkOutput(input string name, input int sel, input logic [31:0] exp);
    expect_t e;
    e.name = name;
    e.sel  = sel;
    e.exp  = exp;
    scoreQ.push_back(e);
  endtask

  // Monitor: every expectation queued at a falling edge is compared 1 time unit later.
  initial begin
    expect_t     e;
    logic [31:0] obs;
    forever begin
      @(negedge clk);
      #1;
      while (scoreQ.size() > 0) begin
        e = scoreQ.pop_front();
        case (e.sel)
          SEL_RD:   obs = bus.rddata;
          SEL_HIT:  obs = {31'b0, bus.hit};
          SEL_HEX:  obs = {4'b0, HEX};
          SEL_LEDR: obs = {22'b0, LEDR};
          default:  obs = {24'b0, LEDG};
        endcase
        testsRun++;
        if (obs !== e.exp) begin
          testsFailed++;
          $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", e.name, obs, e.exp);
        end
      end
    end
  end

  initial begin
    reset = 1'b0;
    KEY   = 4'hF;
    SW    = '0;
    applyStimulus(32'h0, 32'h0, 1'b0, 1'b0);

    tick(2);
    checkOutput("reset_hit", SEL_HIT, 0);
    checkOutput("reset_rd_outside", SEL_RD, 0);
    checkOutput("reset_hex", SEL_HEX, HEX_RESET);
    checkOutput("reset_ledr", SEL_LEDR, 0);
    checkOutput("reset_ledg", SEL_LEDG, 0);
    tick(1);
    applyStimulus(A_KCTL, 0, 0, 0);
    checkOutput("reset_kctrl", SEL_RD, 0);
    tick(1);
    reset = 1'b1;

    tick(1);
    applyStimulus(A_HEX, 32'h0000A5C3, 1, 0);
    checkOutput("hex_old_on_write", SEL_RD, 0);
    tick(1);
    applyStimulus(A_HEX, 0, 0, 0);
    checkOutput("hex_segments", SEL_HEX, HEX_A5C3);
    checkOutput("hex_readback", SEL_RD, 32'hA5C3);
    tick(1);
    applyStimulus(A_LEDR, 32'hFFFFFFFF, 1, 0);
    tick(1);
    applyStimulus(A_LEDR, 0, 0, 0);
    checkOutput("ledr_reg", SEL_LEDR, 32'h3FF);
    checkOutput("ledr_readback", SEL_RD, 32'h3FF);
    tick(1);
    applyStimulus(A_LEDG, 32'h000001A5, 1, 0);
    tick(1);
    applyStimulus(A_LEDG, 0, 0, 0);
    checkOutput("ledg_reg", SEL_LEDG, 32'hA5);

    // Short glitch on KEY[1] must be rejected.
    tick(1);
    KEY = 4'b1101;
    applyStimulus(A_KDAT, 0, 0, 0);
    tick(5);
    KEY = 4'hF;
    tick(12);
    checkOutput("glitch_kdata", SEL_RD, 0);
    tick(1);
    applyStimulus(A_KCTL, 0, 0, 0);
    checkOutput("glitch_ready", SEL_RD, 0);

    // Held press on KEY[1]: accepted exactly 10 edges after the fall.
    tick(1);
    KEY = 4'b1101;
    applyStimulus(A_KDAT, 0, 0, 0);
    tick(9);
    checkOutput("press_kdata_early", SEL_RD, 0);
    tick(1);
    checkOutput("press_kdata", SEL_RD, 32'h2);
    tick(1);
    applyStimulus(A_KCTL, 0, 0, 0);
    checkOutput("press_ready", SEL_RD, 32'h1);

    // Second press with ready still set.
    KEY = 4'hF;
    tick(12);
    KEY = 4'b1110;
    tick(12);
    checkOutput("overrun_set", SEL_RD, 32'h5);
    applyStimulus(A_KCTL, 32'h5, 1, 0);
    tick(1);
    applyStimulus(A_KCTL, 0, 0, 0);
    checkOutput("kctrl_write_ones", SEL_RD, 32'h5);
    applyStimulus(A_KCTL, 32'h1, 1, 0);
    tick(1);
    applyStimulus(A_KCTL, 0, 0, 0);
    checkOutput("kctrl_clear_overrun", SEL_RD, 32'h1);
    applyStimulus(A_KCTL, 32'h0, 1, 0);
    tick(1);
    applyStimulus(A_KCTL, 0, 0, 0);
    checkOutput("kctrl_clear_all", SEL_RD, 0);

    // Press event coinciding with a KDATA read.
    KEY = 4'hF;
    tick(12);
    KEY = 4'b1011;
    applyStimulus(A_KDAT, 0, 0, 0);
    tick(10);
    applyStimulus(A_KDAT, 0, 0, 1);
    checkOutput("coincide_kdata", SEL_RD, 32'h4);
    tick(1);
    applyStimulus(A_KCTL, 0, 0, 0);
    checkOutput("coincide_ready", SEL_RD, 32'h1);
    tick(1);
    applyStimulus(A_KDAT, 0, 0, 1);
    tick(1);
    applyStimulus(A_KCTL, 0, 0, 0);
    checkOutput("read_clears_ready", SEL_RD, 0);

    // Switches.
    tick(1);
    SW = 10'h3FF;
    applyStimulus(A_SDAT, 0, 0, 0);
    tick(9);
    checkOutput("sdata_early", SEL_RD, 0);
    tick(1);
    checkOutput("sdata", SEL_RD, 32'h3FF);

    // Unmapped offset and out-of-window access.
    tick(1);
    applyStimulus(BASE + 32'h1C, 0, 0, 1);
    checkOutput("hole_hit", SEL_HIT, 1);
    checkOutput("hole_read", SEL_RD, 0);
    tick(1);
    applyStimulus(BASE + 32'h20, 32'h0, 1, 0);
    checkOutput("outside_hit", SEL_HIT, 0);
    checkOutput("outside_read", SEL_RD, 0);
    tick(1);
    applyStimulus(A_HEX, 0, 0, 0);
    checkOutput("outside_no_write", SEL_RD, 32'hA5C3);

    // Reset in the middle of a press debounce.
    KEY = 4'hF;
    tick(12);
    KEY = 4'b0111;
    applyStimulus(A_KDAT, 0, 0, 0);
    tick(5);
    reset = 1'b0;
    checkOutput("midreset_kdata", SEL_RD, 0);
    tick(1);
    applyStimulus(A_KCTL, 0, 0, 0);
    checkOutput("midreset_ready", SEL_RD, 0);
    checkOutput("midreset_hex", SEL_HEX, HEX_RESET);
    checkOutput("midreset_ledr", SEL_LEDR, 0);
    tick(1);
    reset = 1'b1;
    applyStimulus(A_KDAT, 0, 0, 0);
    tick(9);
    checkOutput("restart_kdata_early", SEL_RD, 0);
    tick(1);
    checkOutput("restart_kdata", SEL_RD, 32'h8);
    tick(1);
    applyStimulus(A_KCTL, 0, 0, 0);
    checkOutput("restart_ready", SEL_RD, 32'h1);

    tick(2);
    testsRun++;
    if (scoreQ.size() != 0) begin
      testsFailed++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0", scoreQ.size());
    end
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
